input_scatter: RTL



---
 rtl/layer_mux_pkg.sv | 23 ++
 rtl/input_scatter_if.sv | 37 +++
 rtl/input_scatter_lsb_priority_encoder.sv | 27 ++
 rtl/input_scatter.sv | 94 +++++++++
 4 files changed

// File: rtl/layer_mux_pkg.sv
// ============================================================================
// layer_mux_pkg : shared sizing defaults, FSM encoding and index-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package layer_mux_pkg;

  localparam int NEURON_NUM  = 6;
  localparam int VALUE_WIDTH = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Never returns 0, so a single-element vector still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_scatter_if.sv
// ============================================================================
// input_scatter_if : capture request, packed vector input and beat stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface input_scatter_if
  import layer_mux_pkg::*;
#(
  parameter int NEURON_NUM  = layer_mux_pkg::NEURON_NUM,
  parameter int VALUE_WIDTH = layer_mux_pkg::VALUE_WIDTH,
  parameter int INDEX_WIDTH = idx_width(NEURON_NUM)
);

  logic                              start;
  logic [NEURON_NUM*VALUE_WIDTH-1:0] inputs_values;
  logic [NEURON_NUM-1:0]             inputs_valid;
  logic [VALUE_WIDTH-1:0]            outputs_value;
  logic [INDEX_WIDTH-1:0]            outputs_index;
  logic                              outputs_valid;
  logic                              outputs_ready;
  logic                              busy;
  logic                              done;

  modport master (
    input  start, inputs_values, inputs_valid, outputs_ready,
    output outputs_value, outputs_index, outputs_valid, busy, done
  );

  modport slave (
    output start, inputs_values, inputs_valid, outputs_ready,
    input  outputs_value, outputs_index, outputs_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/input_scatter_lsb_priority_encoder.sv
// ============================================================================
// lsb_priority_encoder : index of lowest set mask bit plus any-set flag
// Rev 1.0
// ============================================================================
`default_nettype none

module lsb_priority_encoder #(
  parameter int NEURON_NUM  = 6,
  parameter int INDEX_WIDTH = 3
) (
  input  wire logic [NEURON_NUM-1:0]  i_mask,
  output logic      [INDEX_WIDTH-1:0] o_index,
  output logic                        o_any
);

  // Scanning downward lets the lowest set bit win the final assignment.
  always_comb begin
    o_index = '0;
    o_any   = |i_mask;
    for (int i = NEURON_NUM - 1; i >= 0; i--) begin
      if (i_mask[i]) o_index = INDEX_WIDTH'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_scatter.sv
// ============================================================================
// input_scatter : captures a masked vector, streams it as (index,value) beats
// Rev 1.0   Option: INPUT_SCATTER_ZERO_SKIP_EN drops zero elements at capture
// ============================================================================
`default_nettype none

module input_scatter
  import layer_mux_pkg::*;
#(
  parameter int NEURON_NUM  = layer_mux_pkg::NEURON_NUM,
  parameter int VALUE_WIDTH = layer_mux_pkg::VALUE_WIDTH,
  parameter int INDEX_WIDTH = idx_width(NEURON_NUM)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input_scatter_if.master  bus
);

  logic [1:0]                        r_state;
  logic [NEURON_NUM-1:0]             r_mask;
  logic [NEURON_NUM*VALUE_WIDTH-1:0] r_values;

  logic [NEURON_NUM-1:0]  w_cap_mask;
  logic [INDEX_WIDTH-1:0] w_sel_idx;
  logic                   w_any;
  logic [NEURON_NUM-1:0]  w_onehot;
  logic [NEURON_NUM-1:0]  w_mask_next;
  logic [VALUE_WIDTH-1:0] w_elem [NEURON_NUM];
  logic                   w_send;
  logic                   w_fire;

`ifdef INPUT_SCATTER_ZERO_SKIP_EN
  for (genvar i = 0; i < NEURON_NUM; i++) begin : g_zero_skip
    assign w_cap_mask[i] = bus.inputs_valid[i] &&
                           (bus.inputs_values[i*VALUE_WIDTH +: VALUE_WIDTH] != '0);
  end
`else
  assign w_cap_mask = bus.inputs_valid;
`endif

  for (genvar i = 0; i < NEURON_NUM; i++) begin : g_unpack
    assign w_elem[i] = r_values[i*VALUE_WIDTH +: VALUE_WIDTH];
  end

  lsb_priority_encoder #(
    .NEURON_NUM  (NEURON_NUM),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_lsb_enc (
    .i_mask  (r_mask),
    .o_index (w_sel_idx),
    .o_any   (w_any)
  );

  assign w_send      = (r_state == ST_SEND) && w_any;
  assign w_fire      = w_send && bus.outputs_ready;
  assign w_onehot    = NEURON_NUM'(1) << w_sel_idx;
  assign w_mask_next = r_mask & ~w_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_values <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_values <= bus.inputs_values;
            r_mask   <= w_cap_mask;
            r_state  <= (|w_cap_mask) ? ST_SEND : ST_DONE;
          end
        end
        ST_SEND: begin
          if (w_fire) begin
            r_mask <= w_mask_next;
            if (w_mask_next == '0) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come only from registered mask/values; ready never feeds valid.
  assign bus.outputs_valid = w_send;
  assign bus.outputs_index = w_send ? w_sel_idx : '0;
  assign bus.outputs_value = w_send ? w_elem[w_sel_idx] : '0;
  assign bus.busy          = (r_state == ST_SEND) || (r_state == ST_DONE);
  assign bus.done          = (r_state == ST_DONE);

endmodule

`default_nettype wire
